// File: rtl/wb_uart_fifo_pkg.sv
// Shared definitions for the Wishbone UART: register map, STAT bit positions,
// serializer/deserializer state encodings and the sticky error flag bundle.
package wb_uart_fifo_pkg;

  localparam logic [1:0] ADDR_TX   = 2'd0;
  localparam logic [1:0] ADDR_RX   = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_DIV  = 2'd3;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_TX_BUSY  = 2;
  localparam int STAT_RX_VALID = 3;
  localparam int STAT_RX_OVR   = 4;
  localparam int STAT_TX_OVF   = 5;
  localparam int STAT_FRM_ERR  = 6;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  typedef struct packed {
    logic frm_err;
    logic tx_ovf;
    logic rx_ovr;
  } err_flags_t;

endpackage

// File: rtl/wb_uart_fifo_fifo.sv
// Synchronous FIFO holding bytes queued for transmission; the extra pointer MSB
// distinguishes full from empty when the index bits match.
module wb_uart_fifo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wb_uart_fifo.sv
// Wishbone UART peripheral: register file, FIFO-fed 8N1 transmitter and
// single-register receiver with sticky error flags.
module wb_uart_fifo
  import wb_uart_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DIV_RESET   = 434,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [1:0]       i_wb_addr,
  input  logic [DIV_W-1:0] i_wb_data,
  output logic             o_wb_ack,
  output logic             o_wb_stall,
  output logic [DIV_W-1:0] o_wb_data,
  input  logic             i_uart_rx,
  output logic             o_uart_tx
);

  localparam logic [DIV_W-1:0] DIV_ONE = 1;
  localparam logic [DIV_W-1:0] DIV_MIN = 2;

  logic             bus_acc, bus_wr, bus_rd, stat_wr, rx_read;
  logic             ack_q;
  logic [DIV_W-1:0] rdata_q, div_reg, div_eff;
  err_flags_t       flags;
  logic [7:0]       stat;

  logic             fifo_push, fifo_full, fifo_empty, tx_pop, tx_ovf_evt;
  logic [7:0]       fifo_data, tx_shift;
  logic [1:0]       tx_state;
  logic [DIV_W-1:0] tx_cnt, tx_div;
  logic [2:0]       tx_bit;
  logic             tx_line;

  logic [SYNC_STAGES-1:0] rx_sync;
  logic             rx_s, rx_prev, rx_store, rx_valid, rx_ovr_evt, frm_evt;
  logic [1:0]       rx_state;
  logic [DIV_W-1:0] rx_cnt, rx_div;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift, rx_byte;

  assign bus_acc    = i_wb_cyc && i_wb_stb;
  assign bus_wr     = bus_acc && i_wb_we;
  assign bus_rd     = bus_acc && !i_wb_we;
  assign stat_wr    = bus_wr && (i_wb_addr == ADDR_STAT);
  assign rx_read    = bus_rd && (i_wb_addr == ADDR_RX);
  assign o_wb_ack   = ack_q && i_wb_cyc;
  assign o_wb_stall = 1'b0;
  assign o_wb_data  = rdata_q;
  assign o_uart_tx  = tx_line;
  assign div_eff    = (div_reg < DIV_MIN) ? DIV_MIN : div_reg;

  always_comb begin
    stat                = '0;
    stat[STAT_TX_EMPTY] = fifo_empty && (tx_state == TX_IDLE);
    stat[STAT_TX_FULL]  = fifo_full;
    stat[STAT_TX_BUSY]  = (tx_state != TX_IDLE);
    stat[STAT_RX_VALID] = rx_valid;
    stat[STAT_RX_OVR]   = flags.rx_ovr;
    stat[STAT_TX_OVF]   = flags.tx_ovf;
    stat[STAT_FRM_ERR]  = flags.frm_err;
  end

  // Register file: reads are captured on the accepting edge and shown with ack;
  // a new error event outranks a write-1-to-clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      div_reg <= DIV_W'(DIV_RESET);
      flags   <= '0;
    end else begin
      ack_q   <= bus_acc;
      rdata_q <= '0;
      if (bus_rd) begin
        case (i_wb_addr)
          ADDR_RX:   rdata_q <= DIV_W'(rx_byte);
          ADDR_STAT: rdata_q <= DIV_W'(stat);
          ADDR_DIV:  rdata_q <= div_reg;
          default:   rdata_q <= '0;
        endcase
      end
      if (bus_wr && (i_wb_addr == ADDR_DIV)) div_reg <= i_wb_data;
      flags.rx_ovr  <= (flags.rx_ovr  && !(stat_wr && i_wb_data[STAT_RX_OVR]))  || rx_ovr_evt;
      flags.tx_ovf  <= (flags.tx_ovf  && !(stat_wr && i_wb_data[STAT_TX_OVF]))  || tx_ovf_evt;
      flags.frm_err <= (flags.frm_err && !(stat_wr && i_wb_data[STAT_FRM_ERR])) || frm_evt;
    end
  end

  assign fifo_push  = bus_wr && (i_wb_addr == ADDR_TX);
  assign tx_pop     = !fifo_empty && ((tx_state == TX_IDLE) ||
                                      ((tx_state == TX_STOP) && (tx_cnt == '0)));
  assign tx_ovf_evt = fifo_push && fifo_full && !tx_pop;

  wb_uart_fifo_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (i_wb_data[7:0]),
    .pop       (tx_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Serializer: a pending byte is loaded from IDLE or straight out of the stop
  // bit, so queued bytes go out without an idle gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_div   <= div_eff;
      tx_cnt   <= div_eff - DIV_ONE;
      tx_shift <= fifo_data;
      tx_line  <= 1'b0;
    end else begin
      case (tx_state)
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= tx_div - DIV_ONE;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end else tx_cnt <= tx_cnt - DIV_ONE;
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= tx_div - DIV_ONE;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_line  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else tx_cnt <= tx_cnt - DIV_ONE;
        end
        TX_STOP: begin
          if (tx_cnt == '0) tx_state <= TX_IDLE;
          else              tx_cnt   <= tx_cnt - DIV_ONE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign rx_s       = rx_sync[SYNC_STAGES-1];
  assign rx_store   = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_ovr_evt = rx_store && rx_valid && !rx_read;
  assign frm_evt    = rx_store && !rx_s;

  // Deserializer: the start bit is re-checked half a bit after the falling edge,
  // which rejects short glitches and centres every later sample in its bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync  <= '1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], i_uart_rx};
      rx_prev <= rx_s;
      if (rx_store) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_read) rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_div   <= div_eff;
            rx_cnt   <= (div_eff >> 1) - DIV_ONE;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (!rx_s) begin
              rx_state <= RX_DATA;
              rx_cnt   <= rx_div - DIV_ONE;
              rx_bit   <= '0;
            end else rx_state <= RX_IDLE;
          end else rx_cnt <= rx_cnt - DIV_ONE;
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_cnt   <= rx_div - DIV_ONE;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - DIV_ONE;
        end
        RX_STOP: begin
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else              rx_cnt   <= rx_cnt - DIV_ONE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_fifo.sv
// Bench for wb_uart_fifo: a queue-based model predicts the serial line and bus
// responses every cycle; directed tests add literal expectations on top.
module tb_wb_uart_fifo;
  import wb_uart_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int DIVT  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [1:0]  i_wb_addr = '0;
  logic [15:0] i_wb_data = '0;
  logic        o_wb_ack, o_wb_stall;
  logic [15:0] o_wb_data;
  logic        i_uart_rx = 1'b1;
  logic        o_uart_tx;

  int checks = 0;
  int failures = 0;

  wb_uart_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DIV_RESET(434), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_wb_cyc   (i_wb_cyc),
    .i_wb_stb   (i_wb_stb),
    .i_wb_we    (i_wb_we),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .o_wb_ack   (o_wb_ack),
    .o_wb_stall (o_wb_stall),
    .o_wb_data  (o_wb_data),
    .i_uart_rx  (i_uart_rx),
    .o_uart_tx  (o_uart_tx)
  );

  always #5 clk = ~clk;

  // Model state: bytes waiting in the FIFO, and the expected line as a bit stream.
  logic [7:0]  fifo_q[$];
  logic        line_q[$];
  logic        exp_tx = 1'b1;
  logic        busy_m = 1'b0;
  logic [15:0] div_m = 16'd434;
  logic        ovf_m = 0, ovr_m = 0, frm_m = 0, rxv_m = 0;
  logic [7:0]  rxb_m = '0;
  logic        exp_ack_q = 0, exp_rd_q = 0;
  logic [15:0] exp_data_q = '0;
  int          rx_seq = 0, rx_seen = 0;
  logic [7:0]  rx_req_byte = '0;
  logic        rx_req_stop = 1'b1;
  logic        m_acc;
  logic [15:0] m_rd, m_d;
  logic [9:0]  m_frame;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] model_stat();
    return {1'b0, frm_m, ovf_m, ovr_m, rxv_m, busy_m,
            logic'(fifo_q.size() == DEPTH), logic'(fifo_q.size() == 0 && !busy_m)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q.delete(); line_q.delete();
      exp_tx = 1'b1; busy_m = 1'b0; div_m = 16'd434;
      ovf_m = 0; ovr_m = 0; frm_m = 0; rxv_m = 0; rxb_m = '0;
      exp_ack_q = 0; exp_rd_q = 0; exp_data_q = '0;
      rx_seen = rx_seq;
    end else begin
      if (rx_seen != rx_seq) begin
        if (rxv_m) ovr_m = 1'b1;
        rxv_m = 1'b1;
        rxb_m = rx_req_byte;
        if (!rx_req_stop) frm_m = 1'b1;
        rx_seen = rx_seq;
      end
      m_acc = i_wb_cyc && i_wb_stb;
      m_rd  = '0;
      if (m_acc && !i_wb_we) begin
        case (i_wb_addr)
          ADDR_RX:   m_rd = {8'h00, rxb_m};
          ADDR_STAT: m_rd = {8'h00, model_stat()};
          ADDR_DIV:  m_rd = div_m;
          default:   m_rd = '0;
        endcase
      end
      if (line_q.size() == 0 && fifo_q.size() != 0) begin
        m_frame = {1'b1, fifo_q.pop_front(), 1'b0};
        m_d = (div_m < 16'd2) ? 16'd2 : div_m;
        for (int i = 0; i < 10; i++)
          for (int j = 0; j < int'(m_d); j++) line_q.push_back(m_frame[i]);
      end
      if (line_q.size() != 0) begin
        exp_tx = line_q.pop_front();
        busy_m = 1'b1;
      end else begin
        exp_tx = 1'b1;
        busy_m = 1'b0;
      end
      if (m_acc && i_wb_we) begin
        case (i_wb_addr)
          ADDR_TX: if (fifo_q.size() < DEPTH) fifo_q.push_back(i_wb_data[7:0]);
                   else ovf_m = 1'b1;
          ADDR_STAT: begin
            if (i_wb_data[4]) ovr_m = 1'b0;
            if (i_wb_data[5]) ovf_m = 1'b0;
            if (i_wb_data[6]) frm_m = 1'b0;
          end
          ADDR_DIV: div_m = i_wb_data;
          default: ;
        endcase
      end
      if (m_acc && !i_wb_we && i_wb_addr == ADDR_RX) rxv_m = 1'b0;
      exp_ack_q  = m_acc;
      exp_rd_q   = m_acc && !i_wb_we;
      exp_data_q = m_rd;
    end
  end

  always @(negedge clk) begin
    if (!reset) checkOutput("tx_in_reset", o_uart_tx, 1);
    else begin
      checkOutput("tx_line", o_uart_tx, exp_tx);
      checkOutput("wb_ack", o_wb_ack, exp_ack_q && i_wb_cyc);
      checkOutput("wb_stall", o_wb_stall, 0);
      if (exp_ack_q && exp_rd_q) checkOutput("wb_rdata", o_wb_data, exp_data_q);
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [15:0] data,
                               output logic [15:0] rdata);
    @(posedge clk); #1;
    i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = addr; i_wb_data = data;
    @(posedge clk); #1;
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(negedge clk);
    rdata = o_wb_data;
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      i_uart_rx = f[i];
      repeat (DIVT) @(posedge clk);
      #1;
    end
    i_uart_rx = 1'b1;
    repeat (3 * DIVT) @(posedge clk);
    #1;
    rx_req_byte = b;
    rx_req_stop = stop;
    rx_seq++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [19:0] tx_bits;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    i_wb_cyc = 1'b1;
    checkOutput("reset_tx_high", o_uart_tx, 1);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("reset_stat", rd, 16'h0001);
    applyStimulus(0, ADDR_DIV, 0, rd);  checkOutput("reset_div", rd, 16'd434);
    applyStimulus(1, ADDR_DIV, 16'd4, rd);
    applyStimulus(0, ADDR_DIV, 0, rd);  checkOutput("div_prog", rd, 16'd4);

    $display("[TB] two back-to-back TX bytes");
    tx_bits = {10'b1_10100011_0, 10'b1_01010101_0};
    @(posedge clk); #1;
    i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = ADDR_TX; i_wb_data = 16'h0055;
    @(posedge clk); #1;
    i_wb_data = 16'h00A3;
    @(posedge clk); #1;
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 0) repeat (2) @(negedge clk);
      else        repeat (4) @(negedge clk);
      checkOutput($sformatf("tx_bit%0d", k), o_uart_tx, tx_bits[k]);
    end
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_last_stop", rd, 16'h0004);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_tx_done", rd, 16'h0001);

    $display("[TB] FIFO overflow");
    @(posedge clk); #1;
    i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = ADDR_TX;
    for (int i = 0; i < 6; i++) begin
      i_wb_data = 16'h0011 + 16'(i);
      @(posedge clk); #1;
    end
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_ovf", rd, 16'h0026);
    applyStimulus(1, ADDR_STAT, 16'h0020, rd);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_ovf_clr", rd, 16'h0006);
    repeat (5 * 10 * DIVT + 10) @(posedge clk);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_drained", rd, 16'h0001);

    $display("[TB] RX path");
    drive_rx_frame(8'h3C, 1'b1);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_rx_valid", rd, 16'h0009);
    applyStimulus(0, ADDR_RX, 0, rd);   checkOutput("rx_byte", rd, 16'h003C);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_rx_read", rd, 16'h0001);
    @(posedge clk); #1 i_uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_uart_rx = 1'b1;
    repeat (12) @(posedge clk);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_glitch", rd, 16'h0001);
    drive_rx_frame(8'hA5, 1'b1);
    drive_rx_frame(8'h5A, 1'b1);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_rx_ovr", rd, 16'h0019);
    applyStimulus(0, ADDR_RX, 0, rd);   checkOutput("rx_second", rd, 16'h005A);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_ovr_sticky", rd, 16'h0011);
    drive_rx_frame(8'hC3, 1'b0);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_frm_err", rd, 16'h0059);
    applyStimulus(1, ADDR_STAT, 16'h0070, rd);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_err_clr", rd, 16'h0009);
    applyStimulus(0, ADDR_RX, 0, rd);   checkOutput("rx_frm_byte", rd, 16'h00C3);

    $display("[TB] reset during TX data");
    applyStimulus(1, ADDR_TX, 16'h0000, rd);
    repeat (15) @(posedge clk);
    #1 checkOutput("tx_data_low", o_uart_tx, 0);
    reset = 1'b0;
    #1 checkOutput("reset_mid_tx", o_uart_tx, 1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_after_reset", rd, 16'h0001);
    applyStimulus(0, ADDR_DIV, 0, rd);  checkOutput("div_after_reset", rd, 16'd434);
    applyStimulus(1, ADDR_DIV, 16'd4, rd);
    applyStimulus(1, ADDR_TX, 16'h003A, rd);
    repeat (50) @(posedge clk);
    applyStimulus(0, ADDR_STAT, 0, rd); checkOutput("stat_resume", rd, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
